// File: rtl/softmax_max_sub_pkg.sv
// ============================================================================
// Module   : star_softmax_pkg
// Purpose  : Shared widths, default geometry, FSM state type and saturation
//            limits for the softmax max-subtract stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package star_softmax_pkg;

  localparam int DATA_W    = 32;
  localparam int LANES     = 8;
  localparam int BEATS_MAX = 8;

  // Subtraction is done one bit wider so overflow is visible before clamping
  localparam int EXT_W = DATA_W + 1;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/softmax_max_sub_sat_sub32.sv
// ============================================================================
// Module   : sat_sub32
// Purpose  : One lane of y = sat32(a - b), both operands signed 32-bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_sub32
  import star_softmax_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [EXT_W-1:0] diff;

  assign diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};

  // Clamp when the two top bits of the wide difference disagree
  always_comb begin
    if (diff[EXT_W-1] != diff[EXT_W-2]) begin
      y = diff[EXT_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      y = diff[DATA_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/softmax_max_sub.sv
// ============================================================================
// Module   : softmax_max_sub
// Purpose  : Buffers one row of signed elements while tracking its maximum,
//            then replays the row with the maximum subtracted (saturated).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_max_sub #(
  parameter int LANES     = star_softmax_pkg::LANES,
  parameter int BEATS_MAX = star_softmax_pkg::BEATS_MAX
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*star_softmax_pkg::DATA_W-1:0] in_data,
  input  logic [star_softmax_pkg::DATA_W-1:0]     in_beat_max,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*star_softmax_pkg::DATA_W-1:0] out_data,
  output logic                                   out_last,
  output logic [star_softmax_pkg::DATA_W-1:0]     out_max,
  output logic                                   ovf_err
);

  import star_softmax_pkg::*;

  localparam int CNT_W = $clog2(BEATS_MAX + 1);
  localparam int IDX_W = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
  localparam int ROW_W = LANES * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS_MAX - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [DATA_W-1:0]  run_max;
  logic [ROW_W-1:0]   row_buf [BEATS_MAX];
  logic [ROW_W-1:0]   rd_row;
  logic [ROW_W-1:0]   sub_row;
  logic               in_fire;
  logic               out_fire;
  logic               row_end;
  logic               last_rd;

  assign in_fire  = in_valid  && (state == FILL);
  assign out_fire = out_ready && (state == DRAIN);
  assign row_end  = in_fire && (in_last || (wr_cnt == CNT_FULL));
  assign last_rd  = (rd_cnt == (wr_cnt - CNT_ONE));
  assign rd_row   = row_buf[rd_cnt[IDX_W-1:0]];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: close the row on last/full, reopen after the final output
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (row_end)              state_nxt = DRAIN;
      DRAIN:   if (out_fire && last_rd)  state_nxt = FILL;
      default:                           state_nxt = FILL;
    endcase
  end

  // Handshake outputs follow the phase only, never out_ready
  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && last_rd;
  end

  // Counters, running maximum and sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      run_max <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (in_fire) begin
        wr_cnt <= wr_cnt + CNT_ONE;
        if ((wr_cnt == '0) || ($signed(in_beat_max) > $signed(run_max))) begin
          run_max <= in_beat_max;
        end
        if ((wr_cnt == CNT_FULL) && !in_last) begin
          ovf_err <= 1'b1;
        end
      end
      if (out_fire) begin
        if (last_rd) begin
          wr_cnt <= '0;
          rd_cnt <= '0;
        end else begin
          rd_cnt <= rd_cnt + CNT_ONE;
        end
      end
    end
  end

  // Row storage; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      row_buf[wr_cnt[IDX_W-1:0]] <= in_data;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      sat_sub32 u_sat (
        .a (rd_row[i*DATA_W +: DATA_W]),
        .b (run_max),
        .y (sub_row[i*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Data is forced to zero outside DRAIN so idle outputs are deterministic
  assign out_data = (state == DRAIN) ? sub_row : '0;
  assign out_max  = run_max;

endmodule

`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
// ============================================================================
// Module   : tb_softmax_max_sub
// Purpose  : Self-checking bench for softmax_max_sub with a row-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_softmax_max_sub;

  localparam int LANES     = 8;
  localparam int BEATS_MAX = 8;
  localparam int W         = LANES * 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [31:0]   in_beat_max;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [31:0]   out_max;
  logic          ovf_err;

  softmax_max_sub #(.LANES(LANES), .BEATS_MAX(BEATS_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_beat_max (in_beat_max),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_max     (out_max),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [31:0]  mx;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  row_q[$];
  logic [31:0]   row_max;
  bit            exp_drain;
  bit            exp_ovf;
  bit            rand_ready = 1'b0;
  int            total = 0;
  int            bad   = 0;

  function automatic logic [31:0] sat_ref(input logic [31:0] e, input logic [31:0] m);
    longint d;
    d = longint'($signed(e)) - longint'($signed(m));
    if (d > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (d < -64'sd2147483648) return 32'h8000_0000;
    return d[31:0];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Row-level reference: collect a row, then queue every expected output beat
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      row_q.delete();
      exp_drain = 1'b0;
      exp_ovf   = 1'b0;
      row_max   = '0;
    end else if (!exp_drain && in_valid) begin
      if (row_q.size() == 0 || $signed(in_beat_max) > $signed(row_max)) row_max = in_beat_max;
      row_q.push_back(in_data);
      if (in_last || row_q.size() == BEATS_MAX) begin
        if (!in_last) exp_ovf = 1'b1;
        for (int k = 0; k < row_q.size(); k++) begin
          for (int i = 0; i < LANES; i++) e.data[i*32 +: 32] = sat_ref(row_q[k][i*32 +: 32], row_max);
          e.last = (k == row_q.size() - 1);
          e.mx   = row_max;
          exp_q.push_back(e);
        end
        row_q.delete();
        exp_drain = 1'b1;
      end
    end else if (exp_drain && out_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) exp_drain = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  W'(in_ready),  W'(!exp_drain));
      chk("out_valid", W'(out_valid), W'(exp_drain));
      chk("ovf_err",   W'(ovf_err),   W'(exp_ovf));
      if (exp_drain && exp_q.size() > 0) begin
        chk("out_data", out_data,       exp_q[0].data);
        chk("out_last", W'(out_last),   W'(exp_q[0].last));
        chk("out_max",  W'(out_max),    W'(exp_q[0].mx));
      end
    end
  end

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic send(input logic [W-1:0] d, input logic last);
    logic [31:0] m;
    int n;
    m = d[31:0];
    for (int i = 1; i < LANES; i++) if ($signed(d[i*32 +: 32]) > $signed(m)) m = d[i*32 +: 32];
    in_valid    = 1'b1;
    in_data     = d;
    in_beat_max = m;
    in_last     = last;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    rand_ready = 1'b1;
    n = 0;
    while (exp_drain && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: out_valid=%0b want 0", out_valid);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_last",  W'(out_last),  W'(1'b0));
    chk("rst_out_max",   W'(out_max),   W'(32'd0));
    chk("rst_out_data",  out_data,      W'(0));
    chk("rst_ovf_err",   W'(ovf_err),   W'(1'b0));
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] d;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 7))
        0:       d[i*32 +: 32] = 32'h8000_0000;
        1:       d[i*32 +: 32] = 32'h7FFF_FFFF;
        default: d[i*32 +: 32] = $urandom;
      endcase
    end
    return d;
  endfunction

  initial begin
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int len;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_beat_max = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_values();

    // Two-beat row: maxima 5 then 9
    d0 = '0; d0[31:0] = 32'd5; d0[63:32] = 32'd1;
    d1 = '0; d1[31:0] = 32'd9; d1[63:32] = 32'hFFFF_FFFD;
    send(d0, 1'b0);
    send(d1, 1'b1);
    chk("r2_valid_lat", W'(out_valid), W'(1'b1));
    chk("r2_b0_lane0",  W'(out_data[31:0]),  W'(32'hFFFF_FFFC));
    chk("r2_b0_lane1",  W'(out_data[63:32]), W'(32'hFFFF_FFF8));
    chk("r2_b0_last",   W'(out_last), W'(1'b0));
    chk("r2_max",       W'(out_max),  W'(32'd9));
    out_ready = 1'b1;
    @(negedge clk);
    chk("r2_b1_lane0",  W'(out_data[31:0]),  W'(32'd0));
    chk("r2_b1_lane1",  W'(out_data[63:32]), W'(32'hFFFF_FFF4));
    chk("r2_b1_lane2",  W'(out_data[95:64]), W'(32'hFFFF_FFF7));
    chk("r2_b1_last",   W'(out_last), W'(1'b1));
    @(negedge clk);
    chk("r2_back_fill", W'(in_ready), W'(1'b1));
    out_ready = 1'b0;

    // Saturation toward the negative limit
    d0 = '0; d0[31:0] = 32'h8000_0000; d0[63:32] = 32'h7FFF_FFFF;
    send(d0, 1'b1);
    chk("sat_lane0", W'(out_data[31:0]),  W'(32'h8000_0000));
    chk("sat_lane1", W'(out_data[63:32]), W'(32'd0));
    chk("sat_lane2", W'(out_data[95:64]), W'(32'h8000_0001));
    chk("sat_last",  W'(out_last), W'(1'b1));
    wait_idle();

    // All-negative single beat, max -7
    for (int i = 0; i < LANES; i++) d0[i*32 +: 32] = 32'(-7 - 3 * i);
    send(d0, 1'b1);
    chk("neg_valid_lat", W'(out_valid), W'(1'b1));
    chk("neg_max",       W'(out_max),   W'(32'hFFFF_FFF9));
    chk("neg_lane0",     W'(out_data[31:0]),    W'(32'd0));
    chk("neg_lane7",     W'(out_data[255:224]), W'(32'hFFFF_FFEB));
    wait_idle();

    // Backpressure for three cycles mid-row
    for (int b = 0; b < 4; b++) send(rand_beat(), b == 3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready",  W'(in_ready),  W'(1'b0));
      chk("bp_out_valid", W'(out_valid), W'(1'b1));
    end
    wait_idle();

    // Overrun: nine beats with last only on the ninth
    rand_ready = 1'b1;
    for (int b = 0; b < 9; b++) send(rand_beat(), b == 8);
    wait_idle();
    chk("ovf_sticky", W'(ovf_err), W'(1'b1));

    // Reset in the middle of filling
    for (int b = 0; b < 3; b++) send(rand_beat(), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_values();
    d0 = '0; d0[31:0] = 32'd100;
    d1 = '0; d1[31:0] = 32'd40;
    send(d0, 1'b0);
    send(d1, 1'b1);
    chk("post_rst_max",   W'(out_max),        W'(32'd100));
    chk("post_rst_lane0", W'(out_data[31:0]), W'(32'd0));
    wait_idle();

    // Randomised rows, some longer than the buffer
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 11);
      rand_ready = 1'b1;
      for (int b = 0; b < len; b++) begin
        send(rand_beat(), b == len - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
